// File: rtl/char_rx_pkg.sv
// Shared types and frame constants for the serial character receiver.
package char_rx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        STOP_LEVEL = 1'b1;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; resets to the
// idle line level so reset never looks like a start edge.
module bit_sync
    import char_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Double-register the input; both stages reset to idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= IDLE_LEVEL;
            q    <= IDLE_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/char_rx_deser.sv
// 8N1 serial-to-byte receiver. Samples mid-bit, holds the last good byte on
// char_out, and flags frames whose stop bit reads low.
module char_rx_deser
    import char_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_bit,
    output logic [7:0] char_out,
    output logic       char_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned HALF = CLKS_PER_BIT / 2;
    localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
    // START samples after HALF cycles, later states after a full period;
    // the counter is 0 in the first cycle after entering START.
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_s;
    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 cnt_clr;
    logic                 shift_en;
    logic                 load_char;
    logic                 flag_err;

    bit_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_bit),
        .q   (rx_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        next_state = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        load_char  = 1'b0;
        flag_err   = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (rx_s != IDLE_LEVEL) begin
                    next_state = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr    = 1'b1;
                    next_state = (rx_s == IDLE_LEVEL) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == IDX_LAST) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s == STOP_LEVEL) begin
                        load_char  = 1'b1;
                        next_state = IDLE;
                    end else begin
                        flag_err   = 1'b1;
                        next_state = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_clr = 1'b1;
                if (rx_s == IDLE_LEVEL) begin
                    next_state = IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                next_state = IDLE;
            end
        endcase
    end

    // Bit-period counter, restarted at every sample point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Data bit index and LSB-first shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else if (state != DATA) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            shreg[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
        end
    end

    // Registered outputs: byte is held between good frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_out   <= '0;
            char_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            char_valid <= load_char;
            frame_err  <= flag_err;
            if (load_char) begin
                char_out <= shreg;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_char_rx_deser.sv
// Self-checking bench for char_rx_deser with P=4.
module tb_char_rx_deser;

    localparam int P = 4;
    localparam int H = P / 2;
    localparam int LAT = 2 + H + 9 * P + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_bit = 1'b1;
    logic [7:0] char_out;
    logic       char_valid;
    logic       frame_err;
    logic       busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        logic [7:0] data;
        int         when;
    } exp_t;

    exp_t val_q[$];
    int   err_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_char;
    } vec_t;

    vec_t vecs[6];

    char_rx_deser #(.CLKS_PER_BIT(P)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_bit     (rx_bit),
        .char_out   (char_out),
        .char_valid (char_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    endfunction

    // Output monitor: every pulse must match a queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            last_good = 8'h00;
        end
        if (char_valid && frame_err) begin
            check("valid_and_err_together", 32'd1, 32'd0);
        end
        if (char_valid) begin
            if (val_q.size() == 0) begin
                check("unexpected_char_valid", {24'd0, char_out}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = val_q.pop_front();
                check("char_out_value", {24'd0, char_out}, {24'd0, e.data});
                check("char_valid_cycle", cyc, e.when);
                last_good = e.data;
            end
        end
        if (frame_err) begin
            if (err_q.size() == 0) begin
                check("unexpected_frame_err", cyc, 32'hFFFF_FFFF);
            end else begin
                int w;
                w = err_q.pop_front();
                check("frame_err_cycle", cyc, w);
                check("char_out_held_on_err", {24'd0, char_out}, {24'd0, last_good});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; caller is positioned #1 after an edge. Line ends at stop level.
    task automatic send(input logic [7:0] d, input logic stop);
        logic [9:0] fr;
        exp_t e;
        fr = {stop, d, 1'b0};
        if (stop) begin
            e.data = d;
            e.when = cyc + LAT;
            val_q.push_back(e);
        end else begin
            err_q.push_back(cyc + LAT);
        end
        for (int b = 0; b < 10; b++) begin
            rx_bit = fr[b];
            step(P);
        end
    endtask

    initial begin
        int e0;
        logic [9:0] fr;

        vecs[0] = '{8'h00, 1'b1, 4, 8'h00};
        vecs[1] = '{8'hFF, 1'b1, 4, 8'hFF};
        vecs[2] = '{8'hA5, 1'b1, 0, 8'hA5};
        vecs[3] = '{8'h3C, 1'b1, 6, 8'h3C};
        vecs[4] = '{8'h7A, 1'b0, 8, 8'h3C};
        vecs[5] = '{8'h55, 1'b1, 5, 8'h55};

        // Reset values
        @(posedge clk);
        #1;
        step(3);
        check("rst_char_out", {24'd0, char_out}, 32'h00);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Idle line
        step(50);
        check("idle_char_out", {24'd0, char_out}, 32'h00);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // First character 'a' and its upper-case conversion
        send(8'h61, 1'b1);
        step(3);
        check("a_char_out", {24'd0, char_out}, 32'h61);
        check("a_to_upper", {24'd0, to_upper(char_out)}, 32'h41);
        step(5);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].stop);
            rx_bit = 1'b1;
            step(vecs[i].gap + 2);
            check("vec_char_out", {24'd0, char_out}, {24'd0, vecs[i].exp_char});
        end
        step(10);

        // Single-cycle glitch
        e0 = cyc;
        rx_bit = 1'b0;
        step(1);
        rx_bit = 1'b1;
        step(2 + 1 - 1);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        step(2);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        check("glitch_cycle", cyc - e0, 2 + H + 1);
        step(10);

        // Good frame, bad stop, line held low
        send(8'h61, 1'b1);
        send(8'h7A, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("break_busy", {31'd0, busy}, 32'd1);
        end
        rx_bit = 1'b1;
        step(4);
        check("break_exit_busy", {31'd0, busy}, 32'd0);
        check("break_char_out", {24'd0, char_out}, 32'h61);
        step(10);

        // Back-to-back frames
        send(8'h7A, 1'b1);
        send(8'h41, 1'b1);
        step(4);
        check("b2b_char_out", {24'd0, char_out}, 32'h41);
        step(10);

        // Reset during data bit 4 of 0x5A
        fr = {1'b1, 8'h5A, 1'b0};
        for (int b = 0; b < 5; b++) begin
            rx_bit = fr[b];
            step(P);
        end
        rx_bit = fr[5];
        step(2);
        rst = 1'b1;
        rx_bit = 1'b1;
        step(1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, char_valid}, 32'd0);
        step(2);
        rst = 1'b0;
        step(5);
        check("midrst_char_out", {24'd0, char_out}, 32'h00);
        send(8'h63, 1'b1);
        step(4);
        check("post_rst_char_out", {24'd0, char_out}, 32'h63);

        // Drain and confirm every expectation was met
        step(60);
        check("pending_valid", val_q.size(), 32'd0);
        check("pending_err", err_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_rx_deser.md
# char_rx_deser

Serial-to-byte front end for the character pipeline. It recovers 8N1-framed ASCII characters from a single-wire serial input and presents each completed byte on a stable parallel bus. That bus feeds the `to_upper_gate` case-conversion stage directly, so the converter's input changes only once per received character. Framing errors are flagged and never reach the converter.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Must be even and ≥ 4.
- `clk`  input  1  single system clock; all state changes on rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `rx_bit`  input  1  serial line. Idle high; LSB-first; 1 start bit (0), 8 data bits, 1 stop bit (1).
- `char_out`  output  8  last correctly framed byte; drives `to_upper_gate.IN`.
- `char_valid`  output  1  one-cycle pulse when `char_out` is updated.
- `frame_err`  output  1  one-cycle pulse when the stop bit samples 0.
- `busy`  output  1  high in any state other than IDLE.

## Operation
- `rx_bit` passes through a 2-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- Definitions:
  - P = CLKS_PER_BIT; H = P/2.
  - t0 = the first cycle in IDLE with `rx_s`==0.
  - Sample point k (k=0..9) occurs at cycle t0+H+k·P.
  - Counter width is $clog2(P).
- State machine:
  - IDLE: on `rx_s`==0, go to START with counter cleared.
  - START: at sample 0, if `rx_s`==1 the start is treated as a glitch and the block returns to IDLE with no outputs; otherwise go to DATA.
  - DATA: at samples 1..8, shift `rx_s` into a shift register at bit index k−1 (LSB first). After sample 8, go to STOP.
  - STOP, sample 9 with `rx_s`==1: load `char_out` from the shift register, pulse `char_valid`, go to IDLE.
  - STOP, sample 9 with `rx_s`==0: pulse `frame_err`, leave `char_out` unchanged, go to BREAK.
  - BREAK: wait for `rx_s`==1, then go to IDLE. A start edge is never accepted while the line is held low.
- `char_out` is held between valid frames, so the downstream converter sees a constant input.
- `char_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset values:
  - `char_out`=8'h00, `char_valid`=0, `frame_err`=0, `busy`=0.
  - State is IDLE; counter and shift register are cleared.
  - Both synchronizer flops reset to 1 (idle line).
- Reset asserted mid-frame: the partial frame is discarded and no pulse is produced. After reset releases, the next start edge is detected normally.
- Latency from `rx_bit` to `rx_s`: 2 cycles.
- `char_valid` and `frame_err` pulse in cycle t0+H+9P+1, one cycle after the stop sample, registered. `char_out` carries its new value in that same cycle.
- `busy` rises in the cycle after t0 and falls in the same cycle as the `char_valid`/`frame_err` pulse. In the BREAK case it falls on the return to IDLE.
- Back-to-back frames: a start bit that begins immediately after the stop bit period must be accepted. IDLE is re-entered before the next falling edge reaches `rx_s`.
- Sampling is fixed mid-bit. There is no re-synchronization within a frame.

## Structure
- Package `char_rx_pkg`:
  - State encoding localparams: IDLE, START, DATA, STOP, BREAK (3 bits).
  - Frame constants: DATA_BITS=8, STOP_LEVEL=1, IDLE_LEVEL=1.
- Sub-module `bit_sync`: 2-flop synchronizer with reset value 1, instantiated once for `rx_bit`.
- The top level contains the FSM, bit-period counter, bit index counter (0..7), shift register and output register.

## Test plan
All scenarios use P=4, so H=2.
- Reset, then idle line high for 50 cycles → `char_out`=8'h00, `busy`=0, no pulses.
- Send 0x61 ('a') → `char_valid` pulses exactly at t0+39, `char_out`=8'h61. Chained to `to_upper_gate`, its OUT=8'h41.
- Drive `rx_bit` low for 1 cycle, then high → sample 0 reads 1, return to IDLE, no `char_valid`/`frame_err`, `busy` back to 0 within H+1 cycles.
- Send 0x61 correctly, then a frame of 0x7A with stop bit 0, then hold the line low for 10 cycles → `frame_err` pulses once, `char_out` stays 8'h61, no start is accepted until the line goes high.
- Send 0x7A and 0x41 back-to-back with no idle gap → two `char_valid` pulses 40 cycles apart, `char_out`=8'h7A then 8'h41.
- Assert `rst` during data bit 4 of 0x5A, release it, then send 0x63 → no pulse for the aborted frame, then `char_valid` with `char_out`=8'h63.
